adc_jesd204_chan_pack: RTL and testbench

- Parametrised JESD204 ADC transport and sample packer for the adc_clk domain.
- Splits a link beat into per-channel samples, converts them to 16-bit two's complement, and packs only the enabled channels into full-width DMA words.
- Generalises the fixed 2-channel/4-lane/14-bit ADC wrapper: lane count, channel count and resolution are parameters, and it adds enable-dependent packing, config checking and overflow status.

---
 rtl/adc_jesd204_chan_pack.sv | 136 +++++++++++++
 tb/tb_adc_jesd204_chan_pack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_jesd204_chan_pack.sv
// JESD204 ADC deframer: per-channel sample extraction, 16-bit conversion and enable-dependent packing into DMA words.
// Optional build macro ADC_PACK_SYNC_EN adds adc_sync; packing then waits for a sync after reset or any enable change.
module adc_jesd204_chan_pack #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_CHANNELS    = 2,
  parameter int CHANNEL_WIDTH   = 14,
  parameter bit TWOS_COMPLEMENT = 1,
  localparam int DATA_WIDTH     = 32*NUM_LANES
) (
  input  logic                    adc_clk,
  input  logic                    adc_rst,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_ready,
  input  logic [NUM_CHANNELS-1:0] adc_enable,
  output logic                    adc_valid,
  output logic [DATA_WIDTH-1:0]   adc_data,
  input  logic                    adc_dovf,
  input  logic                    adc_ovf_clr,
  output logic                    adc_ovf,
  output logic                    adc_cfg_err
`ifdef ADC_PACK_SYNC_EN
  ,
  input  logic                    adc_sync
`endif
);

  localparam int S  = DATA_WIDTH/(16*NUM_CHANNELS);
  localparam int NS = NUM_CHANNELS*S;
  localparam int CW = $clog2(NUM_CHANNELS) + 1;

  function automatic logic [15:0] conv(input logic [CHANNEL_WIDTH-1:0] raw);
    logic signed [CHANNEL_WIDTH-1:0] v;
    logic signed [15:0]              r;
    v = raw;
    if (!TWOS_COMPLEMENT) v[CHANNEL_WIDTH-1] = ~v[CHANNEL_WIDTH-1];
    r = v;
    return r;
  endfunction

  // Legal enable patterns have a power-of-two channel count (zero is illegal).
  function automatic logic legal(input logic [NUM_CHANNELS-1:0] en);
    int unsigned e;
    e = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) e += 32'(en[c]);
    return (e != 0) && ((e & (e - 1)) == 0);
  endfunction

  logic [NUM_CHANNELS-1:0] en_q;
  logic                    chg;
  logic                    accept;
  logic                    s1_vld;
  logic [DATA_WIDTH-1:0]   s1_smp;
  logic [DATA_WIDTH-1:0]   conv_beat;
  logic [DATA_WIDTH-1:0]   slice;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   acc_nxt;
  logic [CW-1:0]           cnt;
  logic                    last;
  int                      n_smp;

  assign chg = (adc_enable != en_q);

`ifdef ADC_PACK_SYNC_EN
  logic armed;
  assign accept = rx_valid & rx_ready & legal(adc_enable) & ~chg & (armed | adc_sync);
`else
  assign accept = rx_valid & rx_ready & legal(adc_enable);
`endif

  // Octet swap puts the MSB octet on top before taking the converter bits.
  always_comb begin
    conv_beat = '0;
    for (int i = 0; i < NS; i++) begin
      conv_beat[16*i +: 16] = conv({rx_data[16*i +: 8], rx_data[16*i+8 +: 8]} >> (16 - CHANNEL_WIDTH));
    end
  end

  always_comb begin
    slice = '0;
    n_smp = 0;
    for (int s = 0; s < S; s++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (en_q[c]) begin
          slice[16*n_smp +: 16] = s1_smp[16*(c*S+s) +: 16];
          n_smp++;
        end
      end
    end
    acc_nxt = ((cnt == '0) ? '0 : acc) | (slice << (16*n_smp*int'(cnt)));
    last    = ((int'(cnt) + 1)*n_smp == NS);
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      rx_ready    <= 1'b0;
      adc_valid   <= 1'b0;
      adc_data    <= '0;
      adc_ovf     <= 1'b0;
      adc_cfg_err <= 1'b0;
      en_q        <= adc_enable;
      s1_vld      <= 1'b0;
      s1_smp      <= '0;
      acc         <= '0;
      cnt         <= '0;
`ifdef ADC_PACK_SYNC_EN
      armed       <= 1'b0;
`endif
    end else begin
      rx_ready    <= 1'b1;
      en_q        <= adc_enable;
      adc_cfg_err <= ~legal(adc_enable);
      s1_vld      <= accept;
      if (accept) s1_smp <= conv_beat;
      adc_valid   <= 1'b0;
      // An enable change drops the stage-1 beat and any partial group.
      if (chg) begin
        cnt <= '0;
      end else if (s1_vld && legal(en_q)) begin
        if (last) begin
          adc_valid <= 1'b1;
          adc_data  <= acc_nxt;
          cnt       <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
      end
      adc_ovf <= (adc_valid & adc_dovf) | (adc_ovf & ~adc_ovf_clr);
`ifdef ADC_PACK_SYNC_EN
      armed <= chg ? 1'b0 : (armed | adc_sync);
`endif
    end
  end

endmodule

// File: tb/tb_adc_jesd204_chan_pack.sv
// Directed bench for adc_jesd204_chan_pack: 2-channel two's complement, 2-channel offset binary and 4-channel instances.
module tb_adc_jesd204_chan_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [127:0] rx_data;
  logic [1:0]   en2;
  logic [3:0]   en4;
  logic         dovf;
  logic         clr;

  logic         rdy_a, vld_a, ovf_a, cerr_a;
  logic [127:0] dat_a;
  logic         rdy_b, vld_b, ovf_b, cerr_b;
  logic [127:0] dat_b;
  logic         rdy_c, vld_c, ovf_c, cerr_c;
  logic [127:0] dat_c;

  int checks = 0;
  int errors = 0;
  int pulses;

  localparam logic [127:0] W_V11   = 128'h0000_0000_0000_0000_0000_0000_0000_E001;
  localparam logic [127:0] W_VOB   = 128'hE000_E000_E000_E000_E000_E000_E000_0001;
  localparam logic [127:0] W_B0_11 = 128'h0107_0103_0106_0102_0105_0101_0104_0100;
  localparam logic [127:0] W_B1_11 = 128'hE007_E003_E006_E002_E005_E001_E004_E000;
  localparam logic [127:0] W_01    = 128'hE003_E002_E001_E000_0103_0102_0101_0100;
  localparam logic [127:0] W_4CH   = 128'hE003_E001_E002_E000_0103_0101_0102_0100;
  localparam logic [127:0] W_RST   = 128'h0103_0102_0101_0100_E003_E002_E001_E000;

  logic [127:0] b0, b1;

  always #5 clk = ~clk;

  adc_jesd204_chan_pack #(.NUM_LANES(4), .NUM_CHANNELS(2), .CHANNEL_WIDTH(14), .TWOS_COMPLEMENT(1)) dut (
    .adc_clk(clk), .adc_rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy_a),
    .adc_enable(en2), .adc_valid(vld_a), .adc_data(dat_a), .adc_dovf(dovf), .adc_ovf_clr(clr),
    .adc_ovf(ovf_a), .adc_cfg_err(cerr_a));

  adc_jesd204_chan_pack #(.NUM_LANES(4), .NUM_CHANNELS(2), .CHANNEL_WIDTH(14), .TWOS_COMPLEMENT(0)) dut_ob (
    .adc_clk(clk), .adc_rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy_b),
    .adc_enable(en2), .adc_valid(vld_b), .adc_data(dat_b), .adc_dovf(dovf), .adc_ovf_clr(clr),
    .adc_ovf(ovf_b), .adc_cfg_err(cerr_b));

  adc_jesd204_chan_pack #(.NUM_LANES(4), .NUM_CHANNELS(4), .CHANNEL_WIDTH(14), .TWOS_COMPLEMENT(1)) dut4 (
    .adc_clk(clk), .adc_rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy_c),
    .adc_enable(en4), .adc_valid(vld_c), .adc_data(dat_c), .adc_dovf(dovf), .adc_ovf_clr(clr),
    .adc_ovf(ovf_c), .adc_cfg_err(cerr_c));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample i carries 14-bit value base+i, placed MSB octet first on the link.
  function automatic logic [127:0] mk_beat(input logic [13:0] base);
    logic [127:0] b;
    logic [15:0]  w;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      w = {base + 14'(i), 2'b00};
      b[16*i +: 16] = {w[7:0], w[15:8]};
    end
    return b;
  endfunction

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    en2 = 2'b11; en4 = 4'b0011; dovf = 1'b0; clr = 1'b0;
    b0 = mk_beat(14'h0100);
    b1 = mk_beat(14'h2000);
    cyc(); cyc();
    chk("rst_ready", rdy_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_data", dat_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_cfgerr", cerr_a, 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", rdy_a, 1);

    // single vector, both sample formats
    rx_data = 128'h0480; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    chk("vec_valid_t1", vld_a, 0);
    cyc();
    chk("vec_valid_t2", vld_a, 1);
    chk("vec_data_tc", dat_a, W_V11);
    chk("vec_data_ob", dat_b, W_VOB);

    // full rate, all channels
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_data = b1;
    cyc();
    rx_valid = 1'b0;
    chk("b2b_valid0", vld_a, 1);
    chk("b2b_data0", dat_a, W_B0_11);
    cyc();
    chk("b2b_valid1", vld_a, 1);
    chk("b2b_data1", dat_a, W_B1_11);
    cyc();
    chk("b2b_idle", vld_a, 0);
    chk("b2b_hold", dat_a, W_B1_11);

    // one channel: two beats per word
    en2 = 2'b01;
    cyc(); cyc();
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_data = b1;
    cyc();
    rx_valid = 1'b0;
    chk("en01_valid_t1", vld_a, 0);
    cyc();
    chk("en01_valid_t2", vld_a, 1);
    chk("en01_data", dat_a, W_01);
    cyc();
    chk("en01_single", vld_a, 0);

    // partial group abandoned by enable change
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_valid = 1'b0;
    cyc();
    en2 = 2'b11;
    cyc();
    chk("sw_no_partial", vld_a, 0);
    rx_valid = 1'b1; rx_data = b1;
    cyc();
    rx_valid = 1'b0;
    chk("sw_valid_t1", vld_a, 0);
    cyc();
    chk("sw_valid_t2", vld_a, 1);
    chk("sw_data", dat_a, W_B1_11);

    // four channels: illegal then legal enable
    en4 = 4'b0111;
    cyc();
    chk("cfg_err_set", cerr_c, 1);
    pulses = 0;
    rx_valid = 1'b1; rx_data = b0;
    cyc(); pulses += int'(vld_c);
    rx_data = b1;
    cyc(); pulses += int'(vld_c);
    rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); pulses += int'(vld_c);
    end
    chk("cfg_err_no_valid", pulses, 0);
    en4 = 4'b0011;
    cyc();
    chk("cfg_err_clear", cerr_c, 0);
    cyc();
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_data = b1;
    cyc();
    rx_valid = 1'b0;
    chk("ch4_valid_t1", vld_c, 0);
    cyc();
    chk("ch4_valid_t2", vld_c, 1);
    chk("ch4_data", dat_c, W_4CH);
    pulses = 0;
    rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx_data = (k % 2 == 0) ? b0 : b1;
      cyc(); pulses += int'(vld_c);
    end
    rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); pulses += int'(vld_c);
    end
    chk("ch4_word_per_2beats", pulses, 2);

    // overflow: only counts while adc_valid is high; set beats clear
    dovf = 1'b1;
    cyc(); cyc();
    chk("ovf_no_valid", ovf_a, 0);
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_valid = 1'b0;
    cyc();
    chk("ovf_valid_now", vld_a, 1);
    chk("ovf_not_yet", ovf_a, 0);
    cyc();
    dovf = 1'b0;
    chk("ovf_set", ovf_a, 1);
    cyc();
    chk("ovf_held", ovf_a, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf_cleared", ovf_a, 0);
    rx_valid = 1'b1; rx_data = b1;
    cyc();
    rx_valid = 1'b0;
    cyc();
    dovf = 1'b1; clr = 1'b1;
    cyc();
    dovf = 1'b0; clr = 1'b0;
    chk("ovf_set_wins", ovf_a, 1);

    // reset in the middle of a group
    en2 = 2'b01;
    cyc(); cyc();
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_ready", rdy_a, 0);
    chk("mid_rst_valid", vld_a, 0);
    chk("mid_rst_data", dat_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_cfgerr", cerr_a, 0);
    rst = 1'b0;
    cyc();
    chk("mid_rst_ready_back", rdy_a, 1);
    pulses = 0;
    rx_valid = 1'b1; rx_data = b1;
    cyc(); pulses += int'(vld_a);
    rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); pulses += int'(vld_a);
    end
    chk("mid_rst_no_stale", pulses, 0);
    rx_valid = 1'b1; rx_data = b0;
    cyc();
    rx_valid = 1'b0;
    cyc();
    chk("mid_rst_new_valid", vld_a, 1);
    chk("mid_rst_new_data", dat_a, W_RST);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
